// File: rtl/axi_mem_arbiter.sv
// Arbitrates the IFU fetch port and the LSU load/store port onto one AXI4 master,
// issuing single-beat transactions one at a time with sub-word lane alignment for the LSU.
module axi_mem_arbiter #(
    parameter int unsigned LSU_PRIO = 0
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_done,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_err,

    input  logic        lsu_req,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [1:0]  lsu_size,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_err,

    input  logic        io_master_awready,
    output logic        io_master_awvalid,
    output logic [31:0] io_master_awaddr,
    output logic [3:0]  io_master_awid,
    output logic [7:0]  io_master_awlen,
    output logic [2:0]  io_master_awsize,
    output logic [1:0]  io_master_awburst,

    input  logic        io_master_wready,
    output logic        io_master_wvalid,
    output logic [31:0] io_master_wdata,
    output logic [3:0]  io_master_wstrb,
    output logic        io_master_wlast,

    output logic        io_master_bready,
    input  logic        io_master_bvalid,
    input  logic [1:0]  io_master_bresp,

    input  logic        io_master_arready,
    output logic        io_master_arvalid,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,

    output logic        io_master_rready,
    input  logic        io_master_rvalid,
    input  logic [1:0]  io_master_rresp,
    input  logic [31:0] io_master_rdata,
    input  logic        io_master_rlast
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_AR = 3'd1;
    localparam logic [2:0] ST_RD_R  = 3'd2;
    localparam logic [2:0] ST_WR    = 3'd3;
    localparam logic [2:0] ST_WR_B  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    function automatic logic [31:0] lane_mask(input logic [1:0] size);
        case (size)
            2'd0:    lane_mask = 32'h0000_00FF;
            2'd1:    lane_mask = 32'h0000_FFFF;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [3:0] strb_base(input logic [1:0] size);
        case (size)
            2'd0:    strb_base = 4'b0001;
            2'd1:    strb_base = 4'b0011;
            default: strb_base = 4'b1111;
        endcase
    endfunction

    logic [2:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic        rr_q, rr_d;          // 1: LSU wins the next tie
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;

    logic        lsu_misaligned;
    logic        grant_lsu;
    logic        grant_ifu;
    logic        rd_fire;
    logic        wr_fire;
    logic [31:0] rd_shifted;

    assign lsu_misaligned = (lsu_size == 2'd3)
                         || (lsu_size == 2'd1 && lsu_addr[0])
                         || (lsu_size == 2'd2 && lsu_addr[1:0] != 2'b00);

    assign grant_lsu = lsu_req && (!ifu_req || (LSU_PRIO != 0) || rr_q);
    assign grant_ifu = ifu_req && !grant_lsu;

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_lsu) begin
                    owner_d = OWNER_LSU;
                    rr_d    = 1'b0;
                    addr_d  = lsu_addr;
                    size_d  = lsu_size;
                    wdata_d = (lsu_wdata & lane_mask(lsu_size)) << {lsu_addr[1:0], 3'b000};
                    wstrb_d = strb_base(lsu_size) << lsu_addr[1:0];
                    if (lsu_misaligned) begin
                        state_d = ST_ERR;
                    end else if (lsu_wen) begin
                        state_d   = ST_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d = ST_RD_AR;
                    end
                end else if (grant_ifu) begin
                    owner_d = OWNER_IFU;
                    rr_d    = 1'b1;
                    addr_d  = ifu_addr;
                    size_d  = 2'd2;
                    state_d = ST_RD_AR;
                end
            end
            ST_RD_AR: if (io_master_arready) state_d = ST_RD_R;
            ST_RD_R:  if (io_master_rvalid)  state_d = ST_IDLE;
            ST_WR: begin
                // AW and W retire independently; leave once both have handshaken.
                awvalid_d = awvalid_q && !io_master_awready;
                wvalid_d  = wvalid_q && !io_master_wready;
                if (!awvalid_d && !wvalid_d) state_d = ST_WR_B;
            end
            ST_WR_B:  if (io_master_bvalid) state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWNER_IFU;
            rr_q      <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
        end
    end

    assign io_master_arvalid = (state_q == ST_RD_AR);
    assign io_master_araddr  = addr_q;
    assign io_master_arsize  = {1'b0, size_q};
    assign io_master_arid    = 4'd0;
    assign io_master_arlen   = 8'd0;
    assign io_master_arburst = 2'b01;
    assign io_master_rready  = (state_q == ST_RD_R);

    assign io_master_awvalid = awvalid_q;
    assign io_master_awaddr  = addr_q;
    assign io_master_awsize  = {1'b0, size_q};
    assign io_master_awid    = 4'd0;
    assign io_master_awlen   = 8'd0;
    assign io_master_awburst = 2'b01;
    assign io_master_wvalid  = wvalid_q;
    assign io_master_wdata   = wdata_q;
    assign io_master_wstrb   = wstrb_q;
    assign io_master_wlast   = wvalid_q;
    assign io_master_bready  = (state_q == ST_WR_B);

    // Single-beat reads only, so the last-beat flag carries no information.
    logic unused_rlast;
    assign unused_rlast = io_master_rlast;

    assign rd_fire    = (state_q == ST_RD_R) && io_master_rvalid;
    assign wr_fire    = (state_q == ST_WR_B) && io_master_bvalid;
    assign rd_shifted = io_master_rdata >> {addr_q[1:0], 3'b000};

    assign ifu_done  = rd_fire && (owner_q == OWNER_IFU);
    assign ifu_rdata = ifu_done ? io_master_rdata : '0;
    assign ifu_err   = ifu_done ? io_master_rresp : '0;

    always_comb begin
        lsu_done  = 1'b0;
        lsu_rdata = '0;
        lsu_err   = 2'b00;
        if (rd_fire && owner_q == OWNER_LSU) begin
            lsu_done  = 1'b1;
            lsu_rdata = rd_shifted & lane_mask(size_q);
            lsu_err   = io_master_rresp;
        end else if (wr_fire) begin
            lsu_done = 1'b1;
            lsu_err  = io_master_bresp;
        end else if (state_q == ST_ERR) begin
            lsu_done = 1'b1;
            lsu_err  = 2'b10;
        end
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: one manually driven instance for protocol timing,
// plus a pair with auto-responding slaves to observe tie-break order for both LSU_PRIO settings.
module tb_axi_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        ifu_req, ifu_done;
    logic [31:0] ifu_addr, ifu_rdata;
    logic [1:0]  ifu_err;
    logic        lsu_req, lsu_wen, lsu_done;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [1:0]  lsu_size, lsu_err;
    logic        awready, awvalid, wready, wvalid, wlast, bready, bvalid;
    logic        arready, arvalid, rready, rvalid, rlast;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  awid, arid, wstrb;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        prio_start;

    int n_checks = 0;
    int n_fail   = 0;

    axi_mem_arbiter #(.LSU_PRIO(0)) u_dut (
        .clock(clock), .reset(reset),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_done(ifu_done),
        .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
        .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .io_master_awready(awready), .io_master_awvalid(awvalid), .io_master_awaddr(awaddr),
        .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize),
        .io_master_awburst(awburst),
        .io_master_wready(wready), .io_master_wvalid(wvalid), .io_master_wdata(wdata),
        .io_master_wstrb(wstrb), .io_master_wlast(wlast),
        .io_master_bready(bready), .io_master_bvalid(bvalid), .io_master_bresp(bresp),
        .io_master_arready(arready), .io_master_arvalid(arvalid), .io_master_araddr(araddr),
        .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
        .io_master_arburst(arburst),
        .io_master_rready(rready), .io_master_rvalid(rvalid), .io_master_rresp(rresp),
        .io_master_rdata(rdata), .io_master_rlast(rlast)
    );

    // Instance k uses LSU_PRIO=k; slave always ready, read data returns the cycle after AR.
    for (genvar k = 0; k < 2; k++) begin : g_arb
        logic        ireq = 1'b0, lreq = 1'b0, rv = 1'b0;
        logic        idone, ldone, arv, rr, awv, wv, wl, br;
        logic [31:0] ard, lrd, ara, awa, wd;
        logic [3:0]  ws, ai, wi;
        logic [7:0]  al, wln;
        logic [2:0]  asz, wsz;
        logic [1:0]  ie, le, ab, wb;
        logic        lsu_log [16];
        int          n_grant = 0;

        axi_mem_arbiter #(.LSU_PRIO(k)) u_arb (
            .clock(clock), .reset(reset),
            .ifu_req(ireq), .ifu_addr(32'h0000_0100), .ifu_done(idone),
            .ifu_rdata(ard), .ifu_err(ie),
            .lsu_req(lreq), .lsu_wen(1'b0), .lsu_addr(32'h0000_0200), .lsu_size(2'd2),
            .lsu_wdata(32'h0), .lsu_done(ldone), .lsu_rdata(lrd), .lsu_err(le),
            .io_master_awready(1'b1), .io_master_awvalid(awv), .io_master_awaddr(awa),
            .io_master_awid(wi), .io_master_awlen(wln), .io_master_awsize(wsz),
            .io_master_awburst(wb),
            .io_master_wready(1'b1), .io_master_wvalid(wv), .io_master_wdata(wd),
            .io_master_wstrb(ws), .io_master_wlast(wl),
            .io_master_bready(br), .io_master_bvalid(1'b0), .io_master_bresp(2'b00),
            .io_master_arready(1'b1), .io_master_arvalid(arv), .io_master_araddr(ara),
            .io_master_arid(ai), .io_master_arlen(al), .io_master_arsize(asz),
            .io_master_arburst(ab),
            .io_master_rready(rr), .io_master_rvalid(rv), .io_master_rresp(2'b00),
            .io_master_rdata(32'h0), .io_master_rlast(1'b1)
        );

        always @(posedge clock) begin
            rv <= arv;
            if (reset) begin
                ireq <= 1'b0;
                lreq <= 1'b0;
            end else if (prio_start) begin
                ireq <= 1'b1;
                lreq <= 1'b1;
            end else begin
                if (idone) ireq <= 1'b0;
                if (ldone) lreq <= 1'b0;
            end
            if (arv && n_grant < 16) begin
                lsu_log[n_grant] <= (ara == 32'h0000_0200);
                n_grant <= n_grant + 1;
            end
        end
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({arvalid, awvalid, wvalid, rready, bready, ifu_done, lsu_done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {arvalid, awvalid, wvalid, rready, bready, ifu_done, lsu_done});
        end
        n_checks++;
        if ({ifu_rdata, lsu_rdata, ifu_err, lsu_err} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%b/%b expected zeros", ifu_rdata, lsu_rdata, ifu_err, lsu_err);
        end
        n_checks++;
        if ({arid, arlen, arburst, awid, awlen, awburst} !== {4'd0, 8'd0, 2'b01, 4'd0, 8'd0, 2'b01}) begin
            n_fail++;
            $display("FAIL burst_consts: got ar %h/%h/%b aw %h/%h/%b expected 0/0/01", arid, arlen, arburst, awid, awlen, awburst);
        end
    endtask

    task automatic test_ifu_fetch();
        @(negedge clock);
        ifu_req = 1'b1; ifu_addr = 32'h8000_0000;
        @(negedge clock);
        n_checks++;
        if ({arvalid, araddr, arsize, ifu_done} !== {1'b1, 32'h8000_0000, 3'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL fetch_ar: got v=%b a=%h s=%0d d=%b expected v=1 a=80000000 s=2 d=0", arvalid, araddr, arsize, ifu_done);
        end
        @(negedge clock);
        n_checks++;
        if ({arvalid, araddr} !== {1'b1, 32'h8000_0000}) begin
            n_fail++;
            $display("FAIL fetch_ar_hold: got v=%b a=%h expected v=1 a=80000000", arvalid, araddr);
        end
        arready = 1'b1;
        @(negedge clock);
        arready = 1'b0;
        n_checks++;
        if ({arvalid, rready} !== 2'b01) begin
            n_fail++;
            $display("FAIL fetch_r_state: got arvalid=%b rready=%b expected 0/1", arvalid, rready);
        end
        rvalid = 1'b1; rdata = 32'h0000_0413; rresp = 2'b00;
        #1;
        n_checks++;
        if ({ifu_done, ifu_rdata, ifu_err, lsu_done} !== {1'b1, 32'h0000_0413, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL fetch_done: got d=%b data=%h err=%b lsu_d=%b expected 1/00000413/00/0", ifu_done, ifu_rdata, ifu_err, lsu_done);
        end
        ifu_req = 1'b0;
        @(negedge clock);
        rvalid = 1'b0; rdata = '0;
        n_checks++;
        if ({ifu_done, rready, arvalid} !== 3'b000) begin
            n_fail++;
            $display("FAIL fetch_pulse: got done=%b rready=%b arvalid=%b expected 000", ifu_done, rready, arvalid);
        end
    endtask

    task automatic test_store_byte();
        @(negedge clock);
        lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0003; lsu_size = 2'd0; lsu_wdata = 32'h0000_00AB;
        @(negedge clock);
        n_checks++;
        if ({awvalid, wvalid, wlast, awaddr, awsize} !== {3'b111, 32'h8000_0003, 3'd0}) begin
            n_fail++;
            $display("FAIL sb_aw: got v=%b%b%b a=%h s=%0d expected 111 80000003 0", awvalid, wvalid, wlast, awaddr, awsize);
        end
        n_checks++;
        if ({wdata, wstrb, bready, arvalid} !== {32'hAB00_0000, 4'b1000, 2'b00}) begin
            n_fail++;
            $display("FAIL sb_w: got d=%h strb=%b bready=%b arvalid=%b expected ab000000 1000 0 0", wdata, wstrb, bready, arvalid);
        end
        awready = 1'b1; wready = 1'b1;
        @(negedge clock);
        awready = 1'b0; wready = 1'b0;
        n_checks++;
        if ({awvalid, wvalid, bready, lsu_done} !== 4'b0010) begin
            n_fail++;
            $display("FAIL sb_wait_b: got aw=%b w=%b bready=%b done=%b expected 0010", awvalid, wvalid, bready, lsu_done);
        end
        bvalid = 1'b1; bresp = 2'b00;
        #1;
        n_checks++;
        if ({lsu_done, lsu_err, ifu_done} !== {1'b1, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL sb_done: got done=%b err=%b ifu_done=%b expected 1 00 0", lsu_done, lsu_err, ifu_done);
        end
        lsu_req = 1'b0;
        @(negedge clock);
        bvalid = 1'b0;
        n_checks++;
        if ({lsu_done, bready} !== 2'b00) begin
            n_fail++;
            $display("FAIL sb_after: got done=%b bready=%b expected 00", lsu_done, bready);
        end
    endtask

    task automatic test_load_half();
        @(negedge clock);
        lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0102; lsu_size = 2'd1;
        @(negedge clock);
        n_checks++;
        if ({arvalid, araddr, arsize, awvalid} !== {1'b1, 32'h8000_0102, 3'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL lh_ar: got v=%b a=%h s=%0d aw=%b expected 1 80000102 1 0", arvalid, araddr, arsize, awvalid);
        end
        arready = 1'b1;
        @(negedge clock);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hBEEF_1234; rresp = 2'b00;
        #1;
        n_checks++;
        if ({lsu_done, lsu_rdata, lsu_err, ifu_done} !== {1'b1, 32'h0000_BEEF, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL lh_data: got d=%b data=%h err=%b ifu_d=%b expected 1 0000beef 00 0", lsu_done, lsu_rdata, lsu_err, ifu_done);
        end
        lsu_req = 1'b0;
        @(negedge clock);
        rvalid = 1'b0; rdata = '0;
    endtask

    task automatic test_store_split();
        @(negedge clock);
        lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0010; lsu_size = 2'd2; lsu_wdata = 32'h1234_5678;
        @(negedge clock);  // cycle 1
        n_checks++;
        if ({awvalid, wvalid, wdata, wstrb} !== {2'b11, 32'h1234_5678, 4'b1111}) begin
            n_fail++;
            $display("FAIL sw_c1: got aw=%b w=%b d=%h strb=%b expected 1 1 12345678 1111", awvalid, wvalid, wdata, wstrb);
        end
        wready = 1'b1;
        @(negedge clock);  // cycle 2
        wready = 1'b0;
        n_checks++;
        if ({awvalid, wvalid, bready} !== 3'b100) begin
            n_fail++;
            $display("FAIL sw_c2: got aw=%b w=%b bready=%b expected 100", awvalid, wvalid, bready);
        end
        @(negedge clock);  // cycle 3
        n_checks++;
        if ({awvalid, wvalid, bready, awaddr} !== {3'b100, 32'h8000_0010}) begin
            n_fail++;
            $display("FAIL sw_c3: got aw=%b w=%b bready=%b a=%h expected 100 80000010", awvalid, wvalid, bready, awaddr);
        end
        awready = 1'b1;
        @(negedge clock);  // cycle 4
        awready = 1'b0;
        n_checks++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            n_fail++;
            $display("FAIL sw_c4: got aw=%b w=%b bready=%b expected 001", awvalid, wvalid, bready);
        end
        bvalid = 1'b1; bresp = 2'b01;
        #1;
        n_checks++;
        if ({lsu_done, lsu_err} !== 3'b101) begin
            n_fail++;
            $display("FAIL sw_done: got done=%b err=%b expected 1 01", lsu_done, lsu_err);
        end
        lsu_req = 1'b0;
        @(negedge clock);
        bvalid = 1'b0; bresp = 2'b00;
        n_checks++;
        if ({bready, lsu_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL sw_after: got bready=%b done=%b expected 00", bready, lsu_done);
        end
    endtask

    task automatic test_misaligned();
        logic [1:0]  sizes [3];
        logic [31:0] addrs [3];
        sizes[0] = 2'd2; addrs[0] = 32'h8000_0001;
        sizes[1] = 2'd3; addrs[1] = 32'h8000_0000;
        sizes[2] = 2'd1; addrs[2] = 32'h8000_0003;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            lsu_req = 1'b1; lsu_wen = (i == 2); lsu_addr = addrs[i]; lsu_size = sizes[i];
            @(negedge clock);
            n_checks++;
            if ({arvalid, awvalid, wvalid, lsu_done, lsu_err, lsu_rdata} !== {4'b0001, 2'b10, 32'h0}) begin
                n_fail++;
                $display("FAIL misaligned_%0d: got ar=%b aw=%b w=%b done=%b err=%b data=%h expected 0 0 0 1 10 0",
                         i, arvalid, awvalid, wvalid, lsu_done, lsu_err, lsu_rdata);
            end
            lsu_req = 1'b0;
            @(negedge clock);
            n_checks++;
            if ({lsu_done, arvalid, awvalid} !== 3'b000) begin
                n_fail++;
                $display("FAIL misaligned_after_%0d: got done=%b ar=%b aw=%b expected 000", i, lsu_done, arvalid, awvalid);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        ifu_req = 1'b1; ifu_addr = 32'h8000_0040;
        @(negedge clock);
        arready = 1'b1;
        @(negedge clock);
        arready = 1'b0;
        n_checks++;
        if (rready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_rready: got %b expected 1", rready);
        end
        reset = 1'b1; ifu_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if ({arvalid, rready, awvalid, wvalid, bready, ifu_done} !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_mid_idle: got ar=%b r=%b aw=%b w=%b b=%b d=%b expected all 0",
                     arvalid, rready, awvalid, wvalid, bready, ifu_done);
        end
    endtask

    task automatic test_priority();
        int t;
        for (int r = 0; r < 4; r++) begin
            @(negedge clock);
            prio_start = 1'b1;
            @(negedge clock);
            prio_start = 1'b0;
            t = 0;
            while ((g_arb[0].ireq || g_arb[0].lreq || g_arb[1].ireq || g_arb[1].lreq) && t < 50) begin
                @(negedge clock);
                t++;
            end
            n_checks++;
            if (t >= 50) begin
                n_fail++;
                $display("FAIL prio_timeout_round%0d: requests still pending after %0d cycles, expected completion", r, t);
            end
        end
        n_checks++;
        if (g_arb[0].n_grant != 8 || g_arb[1].n_grant != 8) begin
            n_fail++;
            $display("FAIL prio_grant_count: got %0d/%0d expected 8/8", g_arb[0].n_grant, g_arb[1].n_grant);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (g_arb[0].lsu_log[i] !== ((i % 2) == 1)) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: got lsu=%b expected %b", i, g_arb[0].lsu_log[i], (i % 2) == 1);
            end
            n_checks++;
            if (g_arb[1].lsu_log[i] !== ((i % 2) == 0)) begin
                n_fail++;
                $display("FAIL lsuprio_grant_%0d: got lsu=%b expected %b", i, g_arb[1].lsu_log[i], (i % 2) == 0);
            end
        end
    endtask

    initial begin
        reset = 1'b1; prio_start = 1'b0;
        ifu_req = 1'b0; ifu_addr = '0;
        lsu_req = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_size = '0; lsu_wdata = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b1;

        test_reset();
        test_ifu_fetch();
        test_store_byte();
        test_load_half();
        test_priority();
        test_store_split();
        test_misaligned();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
